// File: rtl/move_committer.sv
// Game-side move committer: owns the committed board, ko board, turn and pass
// count. It pre-screens one move request at a time, runs the board updater on
// legal placements and then commits the result or rejects the move.
module move_committer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         move_valid,
  input  logic [7:0]   move_in,
  input  logic         pass_in,
  output logic         move_ready,
  output logic         upd_start,
  output logic [161:0] upd_board,
  output logic [161:0] upd_ko_board,
  output logic         upd_turn,
  output logic [7:0]   upd_move,
  input  logic [161:0] upd_next_board,
  input  logic         upd_board_valid,
  input  logic         upd_board_invalid,
  output logic [161:0] board_out,
  output logic         result_valid,
  output logic [1:0]   result_code,
  output logic         game_over,
  output logic [8:0]   move_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_WAIT, S_COMMIT, S_PASS, S_DONE
  } state_t;

  state_t          state, state_next;
  logic [80:0][1:0] board, ko;
  logic            turn;
  logic [7:0]      mv;
  logic            is_pass;
  logic [1:0]      pass_cnt;
  logic            over;
  logic [8:0]      count;
  logic [1:0]      code, code_next;
  logic [TW-1:0]   tcnt;

  logic [3:0]      row, col;
  logic            in_range;
  logic [6:0]      cell_idx;
  logic [1:0]      target;

  assign row          = mv[7:4];
  assign col          = mv[3:0];
  assign upd_board    = board;
  assign upd_ko_board = ko;
  assign upd_turn     = turn;
  assign upd_move     = mv;
  assign board_out    = board;
  assign result_code  = code;
  assign game_over    = over;
  assign move_count   = count;

  // Target cell lookup; the index is only meaningful when row/col are in range.
  always_comb begin
    in_range = (row <= 4'd8) && (col <= 4'd8);
    cell_idx = 7'(row) * 7'd9 + 7'(col);
    target   = '0;
    if (in_range) target = board[cell_idx];
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state, handshake outputs and pending result code.
  always_comb begin
    state_next   = state;
    code_next    = code;
    move_ready   = (state == S_IDLE) && !over;
    upd_start    = (state == S_START);
    result_valid = (state == S_DONE);
    case (state)
      S_IDLE:   if (move_valid && !over) state_next = S_CHECK;
      S_CHECK: begin
        if (is_pass) begin
          state_next = S_PASS;
        end else if (!in_range || target != 2'b00) begin
          state_next = S_DONE;
          code_next  = 2'b10;
        end else begin
          state_next = S_START;
        end
      end
      S_START:  state_next = S_WAIT;
      S_WAIT: begin
        // A simultaneous valid+invalid verdict resolves to invalid.
        if (upd_board_invalid) begin
          state_next = S_DONE;
          code_next  = 2'b01;
        end else if (upd_board_valid) begin
          state_next = S_COMMIT;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_next = S_DONE;
          code_next  = 2'b11;
        end
      end
      S_COMMIT: begin
        state_next = S_DONE;
        code_next  = 2'b00;
      end
      S_PASS: begin
        state_next = S_DONE;
        code_next  = 2'b00;
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Game state: request latch, timeout counter, commit and pass bookkeeping.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      board    <= '0;
      ko       <= '0;
      turn     <= 1'b0;
      mv       <= '0;
      is_pass  <= 1'b0;
      pass_cnt <= '0;
      over     <= 1'b0;
      count    <= '0;
      code     <= '0;
      tcnt     <= '0;
    end else begin
      code <= code_next;
      case (state)
        S_IDLE: begin
          if (move_valid && move_ready) begin
            mv      <= move_in;
            is_pass <= pass_in;
          end
        end
        S_START: tcnt <= '0;
        S_WAIT:  tcnt <= tcnt + 1'b1;
        S_COMMIT: begin
          ko       <= board;
          board    <= upd_next_board;
          turn     <= ~turn;
          pass_cnt <= '0;
          if (count != 9'd511) count <= count + 9'd1;
        end
        S_PASS: begin
          ko       <= '0;
          turn     <= ~turn;
          pass_cnt <= pass_cnt + 2'd1;
          if (pass_cnt == 2'd1) over <= 1'b1;
          if (count != 9'd511) count <= count + 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_committer.sv
// Bench for move_committer: stub updater, table of directed moves, randomized
// moves against a cell-array game model, and hand-written reset/game-over cases.
module tb_move_committer;

  logic         clk_in = 0;
  logic         rst_in = 0;
  logic         move_valid = 0;
  logic [7:0]   move_in = '0;
  logic         pass_in = 0;
  logic         move_ready, upd_start, upd_turn, result_valid, game_over;
  logic [161:0] upd_board, upd_ko_board, board_out, upd_next_board;
  logic [7:0]   upd_move;
  logic         upd_board_valid, upd_board_invalid;
  logic [1:0]   result_code;
  logic [8:0]   move_count;

  int checks = 0;
  int errors = 0;

  // Stub updater controls
  int           stub_mode = 0;  // 0 valid, 1 invalid, 2 silent, 3 both
  int           stub_lat  = 1;
  int           pend = 0;
  logic         sv = 0, si = 0, man_v = 0;
  logic [161:0] nb = '0;

  assign upd_board_valid   = sv | man_v;
  assign upd_board_invalid = si;
  assign upd_next_board    = man_v ? {162{1'b1}} : nb;

  move_committer #(.TIMEOUT_CYCLES(256)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .move_valid(move_valid), .move_in(move_in),
    .pass_in(pass_in), .move_ready(move_ready), .upd_start(upd_start),
    .upd_board(upd_board), .upd_ko_board(upd_ko_board), .upd_turn(upd_turn),
    .upd_move(upd_move), .upd_next_board(upd_next_board),
    .upd_board_valid(upd_board_valid), .upd_board_invalid(upd_board_invalid),
    .board_out(board_out), .result_valid(result_valid), .result_code(result_code),
    .game_over(game_over), .move_count(move_count)
  );

  always #5 clk_in = ~clk_in;

  // Updater stub: places the side-to-move's stone and answers after stub_lat cycles.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      pend = 0; sv = 0; si = 0;
    end else begin
      sv = 0; si = 0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          if (stub_mode == 0 || stub_mode == 3) sv = 1;
          if (stub_mode == 1 || stub_mode == 3) si = 1;
        end
      end
      if (upd_start) begin
        int idx;
        pend = stub_lat;
        idx  = int'(upd_move[7:4]) * 9 + int'(upd_move[3:0]);
        nb   = upd_board;
        nb[idx*2 +: 2] = upd_turn ? 2'b10 : 2'b01;
      end
    end
  end

  // Reference game model
  bit [1:0]     mb[81];
  logic [161:0] m_ko;
  bit           m_turn;
  int           m_count, m_passes;
  bit           m_over;

  function automatic logic [161:0] pack_board();
    logic [161:0] b;
    for (int i = 0; i < 81; i++) b[2*i +: 2] = mb[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 81; i++) mb[i] = 2'b00;
    m_ko = '0; m_turn = 0; m_count = 0; m_passes = 0; m_over = 0;
  endtask

  function automatic logic [1:0] model_code(input bit p, input logic [7:0] mv, input int mode);
    int r, c;
    r = int'(mv[7:4]); c = int'(mv[3:0]);
    if (p) return 2'b00;
    if (r > 8 || c > 8) return 2'b10;
    if (mb[r*9+c] != 2'b00) return 2'b10;
    case (mode)
      0: return 2'b00;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 0; move_valid = 0; man_v = 0;
    @(negedge clk_in);
    rst_in = 1;
    model_reset();
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_board"}, board_out, pack_board());
    chk({tag, "_ko"}, upd_ko_board, m_ko);
    chk({tag, "_turn"}, 162'(upd_turn), 162'(m_turn));
    chk({tag, "_count"}, 162'(move_count), 162'(m_count));
    chk({tag, "_over"}, 162'(game_over), 162'(m_over));
  endtask

  task automatic run_move(input bit p, input logic [7:0] mv, input int mode, input int lat,
                          input logic [1:0] exp_code);
    int n, starts, exp_lat;
    bit seen;
    logic [1:0] got;
    @(negedge clk_in);
    stub_mode = mode; stub_lat = lat;
    chk("ready_before", 162'(move_ready), 162'(1));
    move_valid = 1; pass_in = p; move_in = mv;
    n = 0; starts = 0; seen = 0; got = 'x;
    while (!seen && n < 400) begin
      @(negedge clk_in);
      move_valid = 0;
      n++;
      if (upd_start) starts++;
      if (result_valid) begin seen = 1; got = result_code; end
    end
    chk("result_seen", 162'(seen), 162'(1));
    if (exp_code == 2'b10)      exp_lat = 2;
    else if (p)                 exp_lat = 3;
    else if (exp_code == 2'b00) exp_lat = 4 + lat;
    else if (exp_code == 2'b01) exp_lat = 3 + lat;
    else                        exp_lat = 3 + 256;
    chk("code", 162'(got), 162'(exp_code));
    chk("latency", 162'(n), 162'(exp_lat));
    chk("starts", 162'(starts), 162'((!p && exp_code != 2'b10) ? 1 : 0));
    if (exp_code == 2'b00) begin
      if (p) begin
        m_ko = '0;
        m_passes++;
        if (m_passes == 2) m_over = 1;
      end else begin
        m_ko = pack_board();
        mb[int'(mv[7:4])*9 + int'(mv[3:0])] = m_turn ? 2'b10 : 2'b01;
        m_passes = 0;
      end
      m_turn = ~m_turn;
      if (m_count < 511) m_count++;
    end
    check_state("post");
  endtask

  task automatic drop_req();
    int hits;
    @(negedge clk_in);
    chk("ready_over", 162'(move_ready), 162'(0));
    move_valid = 1; pass_in = 0; move_in = 8'h00;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      move_valid = 0;
      if (result_valid || upd_start) hits++;
    end
    chk("dropped", 162'(hits), 162'(0));
    check_state("drop");
  endtask

  typedef struct {
    bit         p;
    logic [7:0] mv;
    int         mode;
    int         lat;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{0, 8'h44, 0, 2, 2'b00});  // black at 4,4
    vecs.push_back('{0, 8'h44, 0, 1, 2'b10});  // occupied
    vecs.push_back('{0, 8'h90, 0, 1, 2'b10});  // row 9
    vecs.push_back('{0, 8'h28, 0, 1, 2'b00});  // white at 2,8
    vecs.push_back('{0, 8'h30, 1, 3, 2'b01});  // updater says illegal
    vecs.push_back('{0, 8'h31, 2, 1, 2'b11});  // updater silent
    vecs.push_back('{0, 8'h32, 3, 1, 2'b01});  // both verdicts -> illegal
    vecs.push_back('{0, 8'h0F, 0, 1, 2'b10});  // col 15
    vecs.push_back('{0, 8'h88, 0, 4, 2'b00});  // corner
    vecs.push_back('{0, 8'h00, 0, 1, 2'b00});  // corner

    do_reset();
    @(negedge clk_in);
    check_state("reset");
    chk("reset_ready", 162'(move_ready), 162'(1));
    chk("reset_rv", 162'(result_valid), 162'(0));
    chk("reset_code", 162'(result_code), 162'(0));

    foreach (vecs[i]) run_move(vecs[i].p, vecs[i].mv, vecs[i].mode, vecs[i].lat, vecs[i].exp_code);

    // Two consecutive passes end the game
    run_move(1, 8'h00, 0, 1, 2'b00);
    run_move(1, 8'h00, 0, 1, 2'b00);
    chk("go_over", 162'(game_over), 162'(1));
    drop_req();

    // Reset in the middle of WAIT, then a stray verdict
    do_reset();
    @(negedge clk_in);
    stub_mode = 2; move_valid = 1; pass_in = 0; move_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      move_valid = 0;
    end
    rst_in = 0;
    @(negedge clk_in);
    rst_in = 1;
    model_reset();
    man_v = 1;
    @(negedge clk_in);
    man_v = 0;
    begin
      int hits = 0;
      for (int i = 0; i < 10; i++) begin
        if (result_valid || upd_start) hits++;
        @(negedge clk_in);
      end
      chk("late_verdict", 162'(hits), 162'(0));
    end
    check_state("midwait");
    chk("midwait_ready", 162'(move_ready), 162'(1));

    // Randomized play against the model
    for (int k = 0; k < 60; k++) begin
      bit p;
      logic [7:0] mv;
      int r, mode, lat;
      if (m_over) begin
        drop_req();
        do_reset();
      end
      p = ($urandom_range(0, 7) == 0);
      mv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      r = $urandom_range(0, 19);
      mode = (r < 13) ? 0 : (r < 17) ? 1 : (r < 19) ? 3 : 2;
      lat = $urandom_range(1, 6);
      run_move(p, mv, mode, lat, model_code(p, mv, mode));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
